core_mem_arbiter: RTL and testbench

//  Parametrised successor to the single-core data-memory path: shares one data-memory

---
 rtl/core_mem_arbiter_if.sv | 36 +++
 rtl/core_mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_core_mem_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals for core_mem_arbiter.
// The arbiter takes the slave modport; the requesters/memory environment takes master.
interface core_mem_arbiter_if #(
    parameter int N_CH = 2,
    parameter int RW   = 16
);
    localparam int IDW = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH-1:0]    i_req;
    logic [N_CH-1:0]    i_we;
    logic [N_CH*RW-1:0] i_addr;
    logic [N_CH*RW-1:0] i_wdata;
    logic [N_CH-1:0]    o_ack;
    logic               o_err;
    logic [RW-1:0]      o_rdata;
    logic               o_mem_req;
    logic               o_mem_we;
    logic [RW-1:0]      o_mem_addr;
    logic [RW-1:0]      o_mem_data;
    logic [RW-1:0]      i_mem_data;
    logic               i_mem_ack;
    logic               o_busy;
    logic [IDW-1:0]     o_gnt_id;

    modport slave (
        input  i_req, i_we, i_addr, i_wdata, i_mem_data, i_mem_ack,
        output o_ack, o_err, o_rdata, o_mem_req, o_mem_we, o_mem_addr,
               o_mem_data, o_busy, o_gnt_id
    );

    modport master (
        output i_req, i_we, i_addr, i_wdata, i_mem_data, i_mem_ack,
        input  o_ack, o_err, o_rdata, o_mem_req, o_mem_we, o_mem_addr,
               o_mem_data, o_busy, o_gnt_id
    );
endinterface

// File: rtl/core_mem_arbiter.sv
// Shares one data-memory port between N_CH requesters, one transaction in flight,
// round-robin or fixed-priority arbitration, optional ack timeout.
//
// state | meaning
// IDLE  | no transaction; arbitrate among i_req
// BUSY  | o_mem_req high, waiting for i_mem_ack or timeout
// RESP  | o_ack (and o_err on timeout) pulsed for this one cycle
module core_mem_arbiter #(
    parameter int N_CH     = 2,
    parameter int RW       = 16,
    parameter int ARB_MODE = 0,
    parameter int TIMEOUT  = 0
) (
    input logic          i_clk,
    input logic          i_rst_n,
    core_mem_arbiter_if.slave bus
);
    localparam int IDW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]   TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [N_CH-1:0] ONE     = N_CH'(1);
    localparam logic [IDW-1:0]  RR_INIT = IDW'(N_CH - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    state_t          state;
    logic [IDW-1:0]  rr;
    logic [CW-1:0]   cnt;
    logic [N_CH-1:0] ack;
    logic            err;
    logic [RW-1:0]   rdata;
    logic            mem_req;
    logic            mem_we;
    logic [RW-1:0]   mem_addr;
    logic [RW-1:0]   mem_data;
    logic            busy;
    logic [IDW-1:0]  gnt_id;

    logic            win_valid;
    logic [IDW-1:0]  win_id;
    logic [IDW-1:0]  arb_idx;
    logic            win_we;
    logic [RW-1:0]   win_addr;
    logic [RW-1:0]   win_wdata;

    // Round-robin searches rr+1, rr+2, ... so the last winner has lowest priority.
    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        arb_idx   = '0;
        if (ARB_MODE == 1) begin
            for (int i = N_CH - 1; i >= 0; i--) begin
                arb_idx = IDW'(i);
                if (bus.i_req[arb_idx]) begin
                    win_valid = 1'b1;
                    win_id    = arb_idx;
                end
            end
        end else begin
            for (int k = 1; k <= N_CH; k++) begin
                arb_idx = IDW'((int'(rr) + k) % N_CH);
                if (!win_valid && bus.i_req[arb_idx]) begin
                    win_valid = 1'b1;
                    win_id    = arb_idx;
                end
            end
        end
    end

    always_comb begin
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (win_id == IDW'(c)) begin
                win_we    = bus.i_we[c];
                win_addr  = bus.i_addr[c*RW +: RW];
                win_wdata = bus.i_wdata[c*RW +: RW];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= S_IDLE;
            rr       <= RR_INIT;
            cnt      <= '0;
            ack      <= '0;
            err      <= 1'b0;
            rdata    <= '0;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            busy     <= 1'b0;
            gnt_id   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (win_valid) begin
                        mem_req  <= 1'b1;
                        mem_we   <= win_we;
                        mem_addr <= win_addr;
                        mem_data <= win_wdata;
                        gnt_id   <= win_id;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // An ack in the terminal timeout cycle still wins.
                    if (bus.i_mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            rdata <= bus.i_mem_data;
                        end
                        ack   <= ONE << gnt_id;
                        state <= S_RESP;
                    end else if (TIMEOUT > 0 && cnt == TO_LAST) begin
                        mem_req <= 1'b0;
                        ack     <= ONE << gnt_id;
                        err     <= 1'b1;
                        rdata   <= '0;
                        state   <= S_RESP;
                    end else if (TIMEOUT > 0) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_RESP: begin
                    ack  <= '0;
                    err  <= 1'b0;
                    cnt  <= '0;
                    busy <= 1'b0;
                    if (ARB_MODE == 0) begin
                        rr <= gnt_id;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_ack      = ack;
    assign bus.o_err      = err;
    assign bus.o_rdata    = rdata;
    assign bus.o_mem_req  = mem_req;
    assign bus.o_mem_we   = mem_we;
    assign bus.o_mem_addr = mem_addr;
    assign bus.o_mem_data = mem_data;
    assign bus.o_busy     = busy;
    assign bus.o_gnt_id   = gnt_id;
endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench for core_mem_arbiter: three instances (2ch RR with timeout,
// 4ch RR, 4ch fixed priority), completions checked against a queue of expectations.
module tb_core_mem_arbiter;
   typedef struct {
      int          ch;
      logic        err;
      logic        chk_rd;
      logic [15:0] rd;
   } exp_t;

   logic clk_sys;
   logic rst_a_b;
   logic rst_bc_b;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   exp_t sb_a[$];
   exp_t sb_b[$];
   exp_t sb_c[$];
   exp_t ea, eb, ec;
   int   ackcyc_b[$];
   int   nack_a = 0, nack_b = 0, nack_c = 0;
   int   mreq_cyc_a = 0;
   int   dly_a = 0;
   int   mcnt_a = 0, mcnt_b = 0, mcnt_c = 0;

   core_mem_arbiter_if #(.N_CH(2), .RW(16)) ifa ();
   core_mem_arbiter_if #(.N_CH(4), .RW(16)) ifb ();
   core_mem_arbiter_if #(.N_CH(4), .RW(16)) ifc ();

   core_mem_arbiter #(.N_CH(2), .RW(16), .ARB_MODE(0), .TIMEOUT(5)) dut_a (
      .i_clk(clk_sys), .i_rst_n(rst_a_b), .bus(ifa.slave));
   core_mem_arbiter #(.N_CH(4), .RW(16), .ARB_MODE(0), .TIMEOUT(0)) dut_b (
      .i_clk(clk_sys), .i_rst_n(rst_bc_b), .bus(ifb.slave));
   core_mem_arbiter #(.N_CH(4), .RW(16), .ARB_MODE(1), .TIMEOUT(0)) dut_c (
      .i_clk(clk_sys), .i_rst_n(rst_bc_b), .bus(ifc.slave));

   function automatic void chk(input string tag, input logic ok);
      checks++;
      if (ok !== 1'b1) begin
         errors++;
         $error("FAIL %s at cycle %0d", tag, cyc);
      end
   endfunction

   initial begin
      clk_sys = 1'b0;
      forever #5 clk_sys = ~clk_sys;
   end

   always @(posedge clk_sys) cyc++;

   // Memory models: ack in the dly-th cycle of o_mem_req (dly 0 = never ack).
   always @(negedge clk_sys) begin
      if (ifa.o_mem_req) begin
         mcnt_a++;
         ifa.i_mem_ack = (dly_a != 0) && (mcnt_a == dly_a);
      end else begin
         mcnt_a = 0;
         ifa.i_mem_ack = 1'b0;
      end
      if (ifb.o_mem_req) begin
         mcnt_b++;
         ifb.i_mem_ack  = (mcnt_b == 1);
         ifb.i_mem_data = ifb.o_mem_addr ^ 16'hA5A5;
      end else begin
         mcnt_b = 0;
         ifb.i_mem_ack = 1'b0;
      end
      if (ifc.o_mem_req) begin
         mcnt_c++;
         ifc.i_mem_ack = (mcnt_c == 1);
      end else begin
         mcnt_c = 0;
         ifc.i_mem_ack = 1'b0;
      end
   end

   // Completion checkers
   always @(negedge clk_sys) begin
      if (ifa.o_mem_req) mreq_cyc_a++;
      if (ifa.o_ack !== 2'b00) begin
         if (sb_a.size() == 0) chk("a_unexpected_ack", ifa.o_ack === 2'b00);
         else begin
            ea = sb_a.pop_front();
            chk("a_ack_onehot", ifa.o_ack === 2'(1 << ea.ch));
            chk("a_err", ifa.o_err === ea.err);
            if (ea.chk_rd) chk("a_rdata", ifa.o_rdata === ea.rd);
         end
         nack_a++;
      end
      if (ifb.o_ack !== 4'b0000) begin
         if (sb_b.size() == 0) chk("b_unexpected_ack", ifb.o_ack === 4'b0000);
         else begin
            eb = sb_b.pop_front();
            chk("b_grant_order", ifb.o_ack === 4'(1 << eb.ch));
            chk("b_err", ifb.o_err === eb.err);
            if (eb.chk_rd) chk("b_rdata", ifb.o_rdata === eb.rd);
         end
         ackcyc_b.push_back(cyc);
         nack_b++;
      end
      if (ifc.o_ack !== 4'b0000) begin
         if (sb_c.size() == 0) chk("c_unexpected_ack", ifc.o_ack === 4'b0000);
         else begin
            ec = sb_c.pop_front();
            chk("c_priority_order", ifc.o_ack === 4'(1 << ec.ch));
            chk("c_err", ifc.o_err === ec.err);
         end
         nack_c++;
      end
   end

   task automatic wait_a(input int n);
      int b = 0;
      while (nack_a < n && b < 200) begin
         @(negedge clk_sys); #1;
         b++;
      end
      chk("a_ack_wait_expired", nack_a >= n);
   endtask

   task automatic wait_b(input int n);
      int b = 0;
      while (nack_b < n && b < 200) begin
         @(negedge clk_sys); #1;
         b++;
      end
      chk("b_ack_wait_expired", nack_b >= n);
   endtask

   task automatic wait_c(input int n);
      int b = 0;
      while (nack_c < n && b < 200) begin
         @(negedge clk_sys); #1;
         b++;
      end
      chk("c_ack_wait_expired", nack_c >= n);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_a_b = 1'b0;
      rst_bc_b = 1'b0;
      ifa.i_req = '0; ifa.i_we = '0; ifa.i_addr = '0; ifa.i_wdata = '0;
      ifa.i_mem_data = '0; ifa.i_mem_ack = 1'b0;
      ifb.i_req = '0; ifb.i_we = '0; ifb.i_addr = '0; ifb.i_wdata = '0;
      ifb.i_mem_data = '0; ifb.i_mem_ack = 1'b0;
      ifc.i_req = '0; ifc.i_we = '0; ifc.i_addr = '0; ifc.i_wdata = '0;
      ifc.i_mem_data = '0; ifc.i_mem_ack = 1'b0;

      repeat (3) @(posedge clk_sys);
      #1;
      chk("rst_busy", ifa.o_busy === 1'b0);
      chk("rst_mem_req", ifa.o_mem_req === 1'b0);
      chk("rst_ack", ifa.o_ack === 2'b00);
      chk("rst_err", ifa.o_err === 1'b0);
      chk("rst_rdata", ifa.o_rdata === 16'h0000);
      chk("rst_gnt_id", ifa.o_gnt_id === 1'b0);
      chk("rst_b_busy", ifb.o_busy === 1'b0);
      @(negedge clk_sys);
      rst_a_b = 1'b1;
      rst_bc_b = 1'b1;
      @(posedge clk_sys); #1;

      // single read, ack 2 cycles after o_mem_req
      dly_a = 2;
      ifa.i_mem_data = 16'hBEEF;
      sb_a.push_back('{0, 1'b0, 1'b1, 16'hBEEF});
      mreq_cyc_a = 0;
      ifa.i_addr = {16'h0000, 16'h0040};
      ifa.i_we = 2'b00;
      ifa.i_req = 2'b01;
      @(posedge clk_sys);
      @(negedge clk_sys);
      chk("t1_mem_req_latency", ifa.o_mem_req === 1'b1);
      chk("t1_mem_we", ifa.o_mem_we === 1'b0);
      chk("t1_mem_addr", ifa.o_mem_addr === 16'h0040);
      chk("t1_gnt_id", ifa.o_gnt_id === 1'b0);
      chk("t1_busy", ifa.o_busy === 1'b1);
      wait_a(1);
      @(posedge clk_sys); #1;
      ifa.i_req = 2'b00;
      chk("t1_mem_req_cycles", mreq_cyc_a === 2);
      @(negedge clk_sys);
      chk("t1_idle_busy", ifa.o_busy === 1'b0);
      chk("t1_idle_ack", ifa.o_ack === 2'b00);
      chk("t1_rdata_held", ifa.o_rdata === 16'hBEEF);

      // write from ch1
      @(posedge clk_sys); #1;
      dly_a = 1;
      sb_a.push_back('{1, 1'b0, 1'b1, 16'hBEEF});
      ifa.i_addr = {16'h00FF, 16'h0000};
      ifa.i_wdata = {16'h1234, 16'h0000};
      ifa.i_we = 2'b10;
      ifa.i_req = 2'b10;
      @(posedge clk_sys);
      @(negedge clk_sys);
      chk("t4_mem_we", ifa.o_mem_we === 1'b1);
      chk("t4_mem_data", ifa.o_mem_data === 16'h1234);
      chk("t4_mem_addr", ifa.o_mem_addr === 16'h00FF);
      chk("t4_gnt_id", ifa.o_gnt_id === 1'b1);
      wait_a(2);
      @(posedge clk_sys); #1;
      ifa.i_req = 2'b00;
      ifa.i_we = 2'b00;

      // timeout with no ack
      @(posedge clk_sys); #1;
      dly_a = 0;
      sb_a.push_back('{0, 1'b1, 1'b1, 16'h0000});
      mreq_cyc_a = 0;
      ifa.i_addr = {16'h0000, 16'h0010};
      ifa.i_req = 2'b01;
      wait_a(3);
      @(posedge clk_sys); #1;
      ifa.i_req = 2'b00;
      chk("t5_timeout_mem_req_cycles", mreq_cyc_a === 5);

      // ack in exactly the 5th BUSY cycle beats the timeout
      @(posedge clk_sys); #1;
      dly_a = 5;
      ifa.i_mem_data = 16'h5A5A;
      sb_a.push_back('{0, 1'b0, 1'b1, 16'h5A5A});
      mreq_cyc_a = 0;
      ifa.i_req = 2'b01;
      wait_a(4);
      @(posedge clk_sys); #1;
      ifa.i_req = 2'b00;
      chk("t5_late_ack_mem_req_cycles", mreq_cyc_a === 5);

      // async reset in the middle of BUSY
      @(posedge clk_sys); #1;
      dly_a = 0;
      ifa.i_addr = {16'h0222, 16'h0111};
      ifa.i_req = 2'b01;
      @(posedge clk_sys);
      @(negedge clk_sys);
      chk("t6_gnt_before_reset", ifa.o_gnt_id === 1'b0);
      chk("t6_mem_req_before_reset", ifa.o_mem_req === 1'b1);
      ifa.i_req = 2'b11;
      @(posedge clk_sys); #3;
      rst_a_b = 1'b0;
      #1;
      chk("t6_mem_req_at_reset", ifa.o_mem_req === 1'b0);
      chk("t6_busy_at_reset", ifa.o_busy === 1'b0);
      chk("t6_ack_at_reset", ifa.o_ack === 2'b00);
      ifa.i_req = 2'b10;
      dly_a = 1;
      ifa.i_mem_data = 16'h7777;
      repeat (2) @(posedge clk_sys);
      @(negedge clk_sys);
      rst_a_b = 1'b1;
      sb_a.push_back('{1, 1'b0, 1'b1, 16'h7777});
      @(posedge clk_sys);
      @(negedge clk_sys);
      chk("t6_fresh_mem_req", ifa.o_mem_req === 1'b1);
      chk("t6_fresh_gnt_id", ifa.o_gnt_id === 1'b1);
      chk("t6_fresh_addr", ifa.o_mem_addr === 16'h0222);
      wait_a(5);
      @(posedge clk_sys); #1;
      ifa.i_req = 2'b00;

      // round-robin contention, 4 channels always requesting
      for (int i = 0; i < 6; i++)
         sb_b.push_back('{i % 4, 1'b0, 1'b1, (16'h0100 + 16'(i % 4)) ^ 16'hA5A5});
      ifb.i_addr = {16'h0103, 16'h0102, 16'h0101, 16'h0100};
      ifb.i_we = 4'b0000;
      ifb.i_req = 4'b1111;
      wait_b(6);
      @(posedge clk_sys); #1;
      ifb.i_req = 4'b0000;
      chk("t2_ack_count", ackcyc_b.size() === 6);
      for (int i = 1; i < ackcyc_b.size(); i++)
         chk("t2_ack_spacing", (ackcyc_b[i] - ackcyc_b[i-1]) === 3);
      repeat (10) @(negedge clk_sys);
      chk("t2_no_extra_acks", nack_b === 6);

      // fixed priority: ch1 before ch3, then ch0 starves ch3
      @(posedge clk_sys); #1;
      sb_c.push_back('{1, 1'b0, 1'b0, 16'h0000});
      sb_c.push_back('{3, 1'b0, 1'b0, 16'h0000});
      ifc.i_req = 4'b1010;
      wait_c(1);
      @(posedge clk_sys); #1;
      ifc.i_req = 4'b1000;
      wait_c(2);
      @(posedge clk_sys); #1;
      ifc.i_req = 4'b0000;
      @(posedge clk_sys); #1;
      for (int i = 0; i < 4; i++)
         sb_c.push_back('{0, 1'b0, 1'b0, 16'h0000});
      ifc.i_req = 4'b1001;
      wait_c(6);
      @(posedge clk_sys); #1;
      ifc.i_req = 4'b0000;
      repeat (10) @(negedge clk_sys);
      chk("t3_no_extra_acks", nack_c === 6);

      chk("sb_a_drained", sb_a.size() === 0);
      chk("sb_b_drained", sb_b.size() === 0);
      chk("sb_c_drained", sb_c.size() === 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
